// File: rtl/gf_pkg.sv
// Shared GF(2^8) definitions: field width, reduction polynomial and the
// dot-product controller state encoding.
package gf_pkg;
  localparam int         GF_W    = 8;
  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^8) multiplier: carry-less 8x8 product reduced mod 0x11B.
module gf_mul
  import gf_pkg::*;
(
  input  logic [GF_W-1:0] in_1,
  input  logic [GF_W-1:0] in_2,
  output logic [GF_W-1:0] out
);

  localparam logic [14:0] POLY_FULL = 15'({1'b1, GF_POLY});

  logic [14:0] prod;
  logic [14:0] red;

  always_comb begin
    prod = '0;
    for (int i = 0; i < GF_W; i++) begin
      if (in_2[i]) prod = prod ^ (15'(in_1) << i);
    end
  end

  // Fold bits 14..8 back down, highest first, so each step clears its bit.
  always_comb begin
    red = prod;
    for (int k = 14; k >= GF_W; k--) begin
      if (red[k]) red = red ^ (POLY_FULL << (k - GF_W));
    end
  end

  assign out = red[GF_W-1:0];

endmodule

// File: rtl/gf_dot_acc.sv
// Streaming GF(2^8) dot product: N_ELEM pairs in, one-stage multiply
// pipeline, XOR accumulation, one-cycle done pulse with the final result.
//
// state | meaning
// IDLE  | waiting for i_start; o_result holds the previous dot product
// RUN   | accepting operand pairs
// DRAIN | last product accumulating
// DONE  | o_done high, o_result final
module gf_dot_acc
  import gf_pkg::*;
#(
  parameter  int N_ELEM = 4,
  localparam int CNT_W  = $clog2(N_ELEM + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_valid,
  input  logic [GF_W-1:0] i_a,
  input  logic [GF_W-1:0] i_b,
  output logic            o_ready,
  output logic [GF_W-1:0] o_result,
  output logic            o_done
);

  state_t           state;
  state_t           state_nxt;
  logic [GF_W-1:0]  acc;
  logic [GF_W-1:0]  p_reg;
  logic             p_valid;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [GF_W-1:0]  mul_out;
  logic             accept;
  logic             last;

  gf_mul u_mul (
    .in_1 (i_a),
    .in_2 (i_b),
    .out  (mul_out)
  );

  assign accept    = i_valid & o_ready;
  assign count_nxt = count + CNT_W'(1);
  assign last      = (count_nxt == CNT_W'(N_ELEM));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (accept && last) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == RUN);
    o_done  = (state == DONE);
  end

  // Accumulation runs every edge a product is pending, overlapping new accepts.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc     <= '0;
      p_reg   <= '0;
      p_valid <= 1'b0;
      count   <= '0;
    end else begin
      if (p_valid) acc <= acc ^ p_reg;
      if (state == IDLE && i_start) begin
        acc     <= '0;
        count   <= '0;
        p_valid <= 1'b0;
      end else if (accept) begin
        p_reg   <= mul_out;
        p_valid <= 1'b1;
        count   <= count_nxt;
      end else begin
        p_valid <= 1'b0;
      end
    end
  end

  assign o_result = acc;

endmodule

// File: tb/tb_gf_dot_acc.sv
// Self-checking bench for gf_dot_acc: N_ELEM=4 and N_ELEM=1 instances,
// checked against a shift-and-add GF(2^8) reference.
module tb_gf_dot_acc;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, valid;
  logic [7:0] a, b;
  logic       ready, done;
  logic [7:0] result;

  logic       s1, v1;
  logic [7:0] a1, b1;
  logic       r1, d1;
  logic [7:0] res1;

  int passed = 0;
  int total  = 0;

  gf_dot_acc #(.N_ELEM(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid),
    .i_a(a), .i_b(b), .o_ready(ready), .o_result(result), .o_done(done)
  );

  gf_dot_acc #(.N_ELEM(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s1), .i_valid(v1),
    .i_a(a1), .i_b(b1), .o_ready(r1), .o_result(res1), .o_done(d1)
  );

  function automatic logic [7:0] gf_ref(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r = 8'h00;
    logic [7:0] t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) r = r ^ t;
      t = t[7] ? ((t << 1) ^ 8'h1B) : (t << 1);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input logic [7:0] va [4], input logic [7:0] vb [4],
                         input int maxgap, output logic [7:0] res,
                         output int ndone, output int lat, output int ready_bad);
    int g;
    ready_bad = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) begin
        if (ready !== 1'b1) ready_bad++;
        step();
      end
      if (ready !== 1'b1) ready_bad++;
      valid = 1'b1; a = va[i]; b = vb[i];
      step();
      valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
    end
    ndone = 0; lat = -1; res = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) begin lat = c; res = result; end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; a = 8'h00; b = 8'h00;
    s1 = 1'b0; v1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
    repeat (2) step();
    total++; if (ready !== 1'b0 || done !== 1'b0) $display("FAIL reset_ctl ready=%b done=%b want 0/0", ready, done); else passed++;
    total++; if (result !== 8'h00) $display("FAIL reset_result got %h want 00", result); else passed++;
    total++; if (r1 !== 1'b0 || d1 !== 1'b0 || res1 !== 8'h00) $display("FAIL reset_n1 ready=%b done=%b res=%h", r1, d1, res1); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [7:0] va [4] = '{8'h57, 8'h02, 8'h53, 8'h01};
    logic [7:0] vb [4] = '{8'h83, 8'h87, 8'hCA, 8'h00};
    logic [7:0] res; int nd, lat, rb;
    run_vec(va, vb, 0, res, nd, lat, rb);
    total++; if (res !== 8'hD5) $display("FAIL directed_result got %h want D5", res); else passed++;
    total++; if (nd != 1 || lat != 1) $display("FAIL directed_done pulses=%0d lat=%0d want 1/1", nd, lat); else passed++;
    total++; if (rb != 0) $display("FAIL directed_ready not-ready cycles=%0d want 0", rb); else passed++;
    total++; if (result !== 8'hD5) $display("FAIL idle_hold got %h want D5", result); else passed++;
  endtask

  task automatic test_gaps();
    logic [7:0] va [4] = '{8'h57, 8'h02, 8'h53, 8'h01};
    logic [7:0] vb [4] = '{8'h83, 8'h87, 8'hCA, 8'h00};
    logic [7:0] res; int nd, lat, rb;
    for (int k = 0; k < 3; k++) begin
      run_vec(va, vb, 3, res, nd, lat, rb);
      total++; if (res !== 8'hD5) $display("FAIL gaps_result[%0d] got %h want D5", k, res); else passed++;
      total++; if (nd != 1 || lat != 1) $display("FAIL gaps_done[%0d] pulses=%0d lat=%0d want 1/1", k, nd, lat); else passed++;
      total++; if (rb != 0) $display("FAIL gaps_ready[%0d] not-ready cycles=%0d want 0", k, rb); else passed++;
    end
  endtask

  task automatic test_cancel();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [7:0] want [3] = '{8'h00, 8'h00, 8'hA5};
    logic [7:0] res; int nd, lat, rb;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin va = '{8'h53, 8'h53, 8'h53, 8'h53}; vb = '{8'hCA, 8'hCA, 8'hCA, 8'hCA}; end
        1: begin va = '{8'h01, 8'h01, 8'h01, 8'h01}; vb = '{8'hA5, 8'hA5, 8'hA5, 8'hA5}; end
        default: begin va = '{8'h01, 8'h00, 8'h00, 8'h00}; vb = '{8'hA5, 8'hFF, 8'h12, 8'h34}; end
      endcase
      run_vec(va, vb, 1, res, nd, lat, rb);
      total++; if (res !== want[k] || nd != 1) $display("FAIL cancel[%0d] got %h pulses=%0d want %h/1", k, res, nd, want[k]); else passed++;
    end
  endtask

  task automatic test_random();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [7:0] exp_r, res; int nd, lat, rb;
    for (int k = 0; k < 6; k++) begin
      exp_r = 8'h00;
      for (int i = 0; i < 4; i++) begin
        va[i] = 8'($urandom_range(255, 0));
        vb[i] = 8'($urandom_range(255, 0));
        exp_r = exp_r ^ gf_ref(va[i], vb[i]);
      end
      run_vec(va, vb, 2, res, nd, lat, rb);
      total++; if (res !== exp_r || nd != 1 || lat != 1) $display("FAIL random[%0d] got %h pulses=%0d lat=%0d want %h/1/1", k, res, nd, lat, exp_r); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] va [4] = '{8'h57, 8'h02, 8'h53, 8'h01};
    logic [7:0] vb [4] = '{8'h83, 8'h87, 8'hCA, 8'h00};
    logic [7:0] res; int nd, lat, rb, spurious;
    start = 1'b1; step(); start = 1'b0;
    valid = 1'b1; a = 8'h57; b = 8'h83; step();
    a = 8'h02; b = 8'h87; step();
    valid = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    total++; if (ready !== 1'b0 || done !== 1'b0 || result !== 8'h00) $display("FAIL reset_mid ready=%b done=%b res=%h want 0/0/00", ready, done, result); else passed++;
    spurious = 0;
    repeat (6) begin step(); if (done === 1'b1) spurious++; end
    total++; if (spurious != 0) $display("FAIL reset_mid_done pulses=%0d want 0", spurious); else passed++;
    run_vec(va, vb, 0, res, nd, lat, rb);
    total++; if (res !== 8'hD5 || nd != 1) $display("FAIL reset_mid_rerun got %h pulses=%0d want D5/1", res, nd); else passed++;
  endtask

  task automatic test_ignore();
    start = 1'b1; step(); start = 1'b0;
    valid = 1'b1; a = 8'h57; b = 8'h83; step();
    start = 1'b1; a = 8'h02; b = 8'h87; step();
    valid = 1'b0; step();
    start = 1'b0; valid = 1'b1; a = 8'h53; b = 8'hCA; step();
    a = 8'h01; b = 8'h00; step();
    a = 8'hFF; b = 8'hFF;
    total++; if (ready !== 1'b0) $display("FAIL fifth_ready got %b want 0", ready); else passed++;
    step();
    valid = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL ignore_done got %b want 1", done); else passed++;
    total++; if (result !== 8'hD5) $display("FAIL ignore_result got %h want D5", result); else passed++;
    start = 1'b1; step(); start = 1'b0;
    step();
    total++; if (ready !== 1'b0 || done !== 1'b0 || result !== 8'hD5) $display("FAIL start_in_done ready=%b done=%b res=%h want 0/0/D5", ready, done, result); else passed++;
  endtask

  task automatic test_single();
    logic [7:0] pa [2] = '{8'h57, 8'h02};
    logic [7:0] pb [2] = '{8'h83, 8'h87};
    logic [7:0] want, res; int nd, lat;
    for (int k = 0; k < 2; k++) begin
      want = gf_ref(pa[k], pb[k]);
      s1 = 1'b1; step(); s1 = 1'b0;
      v1 = 1'b1; a1 = pa[k]; b1 = pb[k]; step();
      v1 = 1'b0;
      total++; if (r1 !== 1'b0) $display("FAIL n1_ready_after got %b want 0", r1); else passed++;
      nd = 0; lat = -1; res = 8'h00;
      for (int c = 1; c <= 6; c++) begin
        step();
        if (d1 === 1'b1) begin nd++; if (lat < 0) begin lat = c; res = res1; end end
      end
      total++; if (res !== want || nd != 1 || lat != 1) $display("FAIL n1[%0d] got %h pulses=%0d lat=%0d want %h/1/1", k, res, nd, lat, want); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gaps();
    test_cancel();
    test_random();
    test_reset_mid();
    test_ignore();
    test_single();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gf_dot_acc.md
Name: gf_dot_acc

Overview:
- Streaming GF(2^8) multiply-accumulate stage that directly feeds the byte-wise GF adder path.
- Accepts N_ELEM operand pairs (a_i, b_i) over a valid/ready handshake and computes the dot product sum(a_i * b_i) in GF(2^8).
- Field polynomial is x^8+x^4+x^3+x+1 (0x11B).
- Used by the SDitH polynomial-evaluation and share-computation datapaths.

Parameters:
- N_ELEM, 4, number of operand pairs per dot product; must be >= 1.
- CNT_W, $clog2(N_ELEM+1), element counter width; derived, not overridden.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_start  input  1  begin new dot product; honoured only in IDLE.
- i_valid  input  1  operand pair valid.
- i_a  input  8  operand a_i.
- i_b  input  8  operand b_i.
- o_ready  output  1  block accepts a pair this cycle.
- o_result  output  8  accumulated dot product.
- o_done  output  1  one-cycle pulse; o_result final.

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst_n is synchronous and active-low.
- Reset values (i_rst_n=0 at an edge):
  - state=IDLE.
  - acc=0x00, o_result=0x00.
  - o_done=0, o_ready=0.
  - count=0.
  - Product register p_reg=0x00; p_valid=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - o_ready=0.
  - i_start=1 at an edge: acc<=0, count<=0, p_valid<=0, go to RUN.
- RUN:
  - o_ready=1 combinationally.
  - An accept edge is one where i_valid&o_ready: p_reg<=gf_mul(i_a,i_b), p_valid<=1, count<=count+1.
  - At an edge with no accept: p_valid<=0.
  - i_valid low stalls the block indefinitely; no timeout.
  - An accept that brings count to N_ELEM moves the FSM to DRAIN.
- Accumulate: at every edge where p_valid=1, acc<=acc^p_reg. This runs in any state and overlaps with new accepts (one-stage pipeline).
- DRAIN:
  - o_ready=0.
  - The final product accumulates at this edge; go to DONE.
- DONE:
  - o_done=1 for exactly one cycle.
  - o_result=acc, final value.
  - Next edge goes to IDLE.
- Latency: final pair accepted at edge k. o_done is high in the cycle after edge k+1. o_result is valid from that cycle.
- o_result is driven from acc. It holds its value through IDLE until the next i_start clears it.
- i_start in RUN, DRAIN or DONE is ignored (no restart, no effect on count or acc).
- i_valid while o_ready=0: no accept, no state change.
- i_a/i_b must be stable only on accept edges.
- Arithmetic:
  - Addition is 8-bit XOR.
  - Multiplication is carry-less 8x8 followed by reduction mod 0x11B. It is purely combinational inside gf_mul, registered once in p_reg.
  - No widths beyond 8 bits leave the multiplier.
- Reset mid-operation (any state): returns to IDLE with the reset values above. No o_done is produced for the aborted vector.
- N_ELEM=1: a single accept goes RUN->DRAIN directly; same latency.

Decomposition:
- Package gf_pkg:
  - GF_W=8.
  - GF_POLY=8'h1B (low byte of 0x11B).
  - State encoding enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module gf_mul:
  - Combinational GF(2^8) multiplier with ports in_1, in_2 [7:0] -> out [7:0].
  - Reusable by other stages.
- Accumulate XOR stays inline; no instance of the adder is needed.

Test Plan:
- Reset, then i_start, then pairs (0x57,0x83),(0x02,0x87),(0x53,0xCA),(0x01,0x00) back-to-back -> o_done pulses 2 cycles after the 4th accept edge; o_result=0xD5.
- Same four pairs with i_valid gaps of 0-3 random cycles -> o_ready stays 1 throughout RUN; o_result=0xD5; exactly one o_done pulse.
- Four copies of (0x53,0xCA) -> o_result=0x00. Four copies of (0x01,0xA5) -> o_result=0x00. Then (0x01,0xA5),(0x00,0xFF),(0x00,0x12),(0x00,0x34) -> o_result=0xA5.
- i_rst_n=0 for one edge after 2 accepts -> o_ready=0, o_result=0x00, no o_done. Then a new i_start with the first vector -> 0xD5.
- i_start pulsed during RUN and during DONE -> ignored; result unchanged (0xD5). A fifth i_valid after the 4th accept is not accepted (o_ready=0).
- N_ELEM=1 build: (0x57,0x83) -> o_result=0xC1 with o_done 2 cycles after the accept edge. (0x02,0x87) -> 0x15.
